// File: rtl/freelist_refill_ctrl.sv
// freelist_refill_ctrl: clears and rebuilds the 4-bank rename free list after reset/flush,
// then compacts ROB releases into lane order. Optional FreeCnt output under FREELIST_CNT_EN.
`default_nettype none

module freelist_refill_ctrl #(
  parameter int PREG_NUM = 128,
  parameter int PREG_W   = 7,
  parameter int ARCH_NUM = 32
) (
  input  logic                Clk,
  input  logic                Rest,
  input  logic                FlushReq,
  input  logic [PREG_NUM-1:0] CommitMap,
  input  logic                RobFreeAble1,
  input  logic                RobFreeAble2,
  input  logic                RobFreeAble3,
  input  logic                RobFreeAble4,
  input  logic [PREG_W-1:0]   RobFreeAddr1,
  input  logic [PREG_W-1:0]   RobFreeAddr2,
  input  logic [PREG_W-1:0]   RobFreeAddr3,
  input  logic [PREG_W-1:0]   RobFreeAddr4,
  output logic                FlAble1,
  output logic                FlAble2,
  output logic                FlAble3,
  output logic                FlAble4,
  output logic [PREG_W-1:0]   FlAddr1,
  output logic [PREG_W-1:0]   FlAddr2,
  output logic [PREG_W-1:0]   FlAddr3,
  output logic [PREG_W-1:0]   FlAddr4,
  output logic                FlClean,
  output logic                RenameHold,
  output logic                RobFreeStall,
`ifdef FREELIST_CNT_EN
  output logic [PREG_W:0]     FreeCnt,
`endif
  output logic                Busy
);

  localparam int GRP_NUM = PREG_NUM / 4;
  localparam int PTR_W   = PREG_W - 2;
  localparam logic [PREG_NUM-1:0] RST_SNAP = {{(PREG_NUM-ARCH_NUM){1'b0}}, {ARCH_NUM{1'b1}}};

  typedef enum logic {SCAN = 1'b0, IDLE = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [PTR_W-1:0]    ptr, ptr_nxt;
  logic [PREG_NUM-1:0] snap, snap_nxt;
  logic [3:0]          able, able_nxt;
  logic [PREG_W-1:0]   addr [4];
  logic [PREG_W-1:0]   addr_nxt [4];
  logic                clean, clean_nxt;
  logic                hold, hold_nxt;
  logic                stall, stall_nxt;
  logic [3:0]          cand_v;
  logic [PREG_W-1:0]   cand_a [4];
  logic [3:0]          rob_v;
  logic [PREG_W-1:0]   rob_a [4];
  logic [2:0]          k;

  assign rob_v = {RobFreeAble4, RobFreeAble3, RobFreeAble2, RobFreeAble1};
  assign rob_a = '{RobFreeAddr1, RobFreeAddr2, RobFreeAddr3, RobFreeAddr4};

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    snap_nxt  = snap;
    clean_nxt = 1'b0;
    hold_nxt  = hold;
    stall_nxt = stall;
    able_nxt  = '0;
    addr_nxt  = '{default: '0};
    cand_v    = '0;
    cand_a    = '{default: '0};
    k         = '0;

    // Candidates are free pregs of the current group in SCAN, ROB releases in IDLE.
    for (int i = 0; i < 4; i++) begin
      if (state == SCAN) begin
        cand_a[i] = {ptr, 2'(i)};
        cand_v[i] = !snap[{ptr, 2'(i)}];
      end else begin
        cand_a[i] = rob_a[i];
        cand_v[i] = rob_v[i];
      end
    end

    for (int i = 0; i < 4; i++) begin
      if (cand_v[i]) begin
        addr_nxt[k[1:0]] = cand_a[i];
        able_nxt[k[1:0]] = 1'b1;
        k = k + 3'd1;
      end
    end

    if (state == SCAN) begin
      ptr_nxt = ptr + 1'b1;
      if (ptr == PTR_W'(GRP_NUM - 1)) begin
        state_nxt = IDLE;
        ptr_nxt   = '0;
      end
    end else begin
      hold_nxt  = 1'b0;
      stall_nxt = 1'b0;
    end

    // A flush restarts the rebuild from any state and drops this cycle's writes.
    if (FlushReq) begin
      state_nxt = SCAN;
      ptr_nxt   = '0;
      snap_nxt  = CommitMap;
      clean_nxt = 1'b1;
      hold_nxt  = 1'b1;
      stall_nxt = 1'b1;
      able_nxt  = '0;
      addr_nxt  = '{default: '0};
    end
  end

  always_ff @(posedge Clk) begin
    if (Rest) begin
      state <= SCAN;
      ptr   <= '0;
      snap  <= RST_SNAP;
      able  <= '0;
      addr  <= '{default: '0};
      clean <= 1'b1;
      hold  <= 1'b1;
      stall <= 1'b1;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      snap  <= snap_nxt;
      able  <= able_nxt;
      addr  <= addr_nxt;
      clean <= clean_nxt;
      hold  <= hold_nxt;
      stall <= stall_nxt;
    end
  end

`ifdef FREELIST_CNT_EN
  logic [PREG_W:0]   free_cnt;
  logic [PREG_W+1:0] cnt_sum;

  assign cnt_sum = {1'b0, free_cnt} + (PREG_W+2)'(able[0]) + (PREG_W+2)'(able[1])
                 + (PREG_W+2)'(able[2]) + (PREG_W+2)'(able[3]);

  always_ff @(posedge Clk) begin
    if (Rest || FlushReq) begin
      free_cnt <= '0;
    end else if (cnt_sum > (PREG_W+2)'(PREG_NUM)) begin
      free_cnt <= (PREG_W+1)'(PREG_NUM);
    end else begin
      free_cnt <= cnt_sum[PREG_W:0];
    end
  end

  assign FreeCnt = free_cnt;
`else
  // Counter disabled: no FreeCnt port and no count state.
`endif

  assign {FlAble4, FlAble3, FlAble2, FlAble1} = able;
  assign FlAddr1      = addr[0];
  assign FlAddr2      = addr[1];
  assign FlAddr3      = addr[2];
  assign FlAddr4      = addr[3];
  assign FlClean      = clean;
  assign RenameHold   = hold;
  assign RobFreeStall = stall;
  assign Busy         = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_freelist_refill_ctrl.sv
// Bench for freelist_refill_ctrl: directed steps plus random ROB/CommitMap traffic against a list-based model.
`default_nettype none

module tb_freelist_refill_ctrl;
  localparam int PN = 128;
  localparam int PW = 7;
  localparam int AN = 32;
  localparam int GN = PN / 4;

  logic          Clk = 1'b0;
  logic          Rest, FlushReq;
  logic [PN-1:0] CommitMap;
  logic          a1, a2, a3, a4;
  logic [PW-1:0] d1, d2, d3, d4;
  logic          FlAble1, FlAble2, FlAble3, FlAble4;
  logic [PW-1:0] FlAddr1, FlAddr2, FlAddr3, FlAddr4;
  logic          FlClean, RenameHold, RobFreeStall, Busy;
`ifdef FREELIST_CNT_EN
  logic [PW:0]   FreeCnt;
`endif

  freelist_refill_ctrl #(.PREG_NUM(PN), .PREG_W(PW), .ARCH_NUM(AN)) dut (
    .Clk(Clk), .Rest(Rest), .FlushReq(FlushReq), .CommitMap(CommitMap),
    .RobFreeAble1(a1), .RobFreeAble2(a2), .RobFreeAble3(a3), .RobFreeAble4(a4),
    .RobFreeAddr1(d1), .RobFreeAddr2(d2), .RobFreeAddr3(d3), .RobFreeAddr4(d4),
    .FlAble1(FlAble1), .FlAble2(FlAble2), .FlAble3(FlAble3), .FlAble4(FlAble4),
    .FlAddr1(FlAddr1), .FlAddr2(FlAddr2), .FlAddr3(FlAddr3), .FlAddr4(FlAddr4),
    .FlClean(FlClean), .RenameHold(RenameHold), .RobFreeStall(RobFreeStall),
`ifdef FREELIST_CNT_EN
    .FreeCnt(FreeCnt),
`endif
    .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Model: cycles since last entry edge, snapshot, list of writes shown this cycle, write count.
  int            m_cyc = 0;
  logic [PN-1:0] m_snap;
  int            m_list[$];
  int            m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d: observed %0d required %0d", tag, m_cyc, obs, exp);
    end
  endtask

  task automatic tick();
    logic          rst_s, fl_s;
    logic [PN-1:0] map_s;
    logic [3:0]    rv;
    int            ra[4];
    int            nl[$];
    int            g;
    rst_s = Rest; fl_s = FlushReq; map_s = CommitMap;
    rv = {a4, a3, a2, a1};
    ra = '{int'(d1), int'(d2), int'(d3), int'(d4)};
    @(posedge Clk);
    if (rst_s || fl_s) begin
      m_cyc  = 0;
      m_snap = rst_s ? {{(PN-AN){1'b0}}, {AN{1'b1}}} : map_s;
      m_cnt  = 0;
    end else begin
      m_cnt = m_cnt + m_list.size();
      if (m_cnt > PN) m_cnt = PN;
      if (m_cyc < 1000) m_cyc++;
      if (m_cyc <= GN) begin
        g = m_cyc - 1;
        for (int j = 0; j < 4; j++) if (!m_snap[4*g+j]) nl.push_back(4*g + j);
      end else begin
        for (int j = 0; j < 4; j++) if (rv[j]) nl.push_back(ra[j]);
      end
    end
    m_list = nl;
    #1;
    chk("clean", 32'(FlClean), 32'(m_cyc == 0));
    chk("hold",  32'(RenameHold), 32'(m_cyc <= GN));
    chk("stall", 32'(RobFreeStall), 32'(m_cyc <= GN));
    chk("busy",  32'(Busy), 32'(m_cyc < GN));
    chk("able",  32'({FlAble4, FlAble3, FlAble2, FlAble1}), (32'd1 << m_list.size()) - 32'd1);
    chk("addr1", 32'(FlAddr1), m_list.size() > 0 ? 32'(m_list[0]) : 32'd0);
    chk("addr2", 32'(FlAddr2), m_list.size() > 1 ? 32'(m_list[1]) : 32'd0);
    chk("addr3", 32'(FlAddr3), m_list.size() > 2 ? 32'(m_list[2]) : 32'd0);
    chk("addr4", 32'(FlAddr4), m_list.size() > 3 ? 32'(m_list[3]) : 32'd0);
`ifdef FREELIST_CNT_EN
    chk("cnt", 32'(FreeCnt), 32'(m_cnt));
`endif
  endtask

  task automatic rand_rob();
    {a4, a3, a2, a1} = 4'($urandom_range(0, 15));
    d1 = PW'($urandom_range(0, PN-1)); d2 = PW'($urandom_range(0, PN-1));
    d3 = PW'($urandom_range(0, PN-1)); d4 = PW'($urandom_range(0, PN-1));
  endtask

  task automatic run(input int n);
    repeat (n) begin rand_rob(); tick(); end
  endtask

  function automatic logic [PN-1:0] rand_map();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    Rest = 1'b1; FlushReq = 1'b0; CommitMap = '0;
    {a4, a3, a2, a1} = 4'h0; d1 = '0; d2 = '0; d3 = '0; d4 = '0;
    tick(); tick();
    Rest = 1'b0;
    chk("rst_clean0", 32'(FlClean), 32'd1);

    // Reset scan with every ROB lane asserted: releases must be ignored.
    while (m_cyc < 9) begin {a4, a3, a2, a1} = 4'hF; d1 = 7'd1; d2 = 7'd2; tick(); end
    chk("rst_c9_l1", 32'(FlAddr1), 32'd32);
    chk("rst_c9_l4", 32'(FlAddr4), 32'd35);
    while (m_cyc < 31) begin {a4, a3, a2, a1} = 4'hF; tick(); end
    {a4, a3, a2, a1} = 4'h0;
    tick();
    chk("rst_c32_l1", 32'(FlAddr1), 32'd124);
    chk("rst_c32_l4", 32'(FlAddr4), 32'd127);
    chk("rst_c32_busy", 32'(Busy), 32'd0);
    tick();
    chk("rst_c33_hold", 32'(RenameHold), 32'd0);
`ifdef FREELIST_CNT_EN
    chk("rst_c33_cnt", 32'(FreeCnt), 32'd96);
`endif

    // Sparse release packs into lanes 1,2.
    a2 = 1'b1; d2 = 7'd40; a4 = 1'b1; d4 = 7'd77;
    tick();
    chk("idle_able", 32'({FlAble4, FlAble3, FlAble2, FlAble1}), 32'h3);
    chk("idle_a1", 32'(FlAddr1), 32'd40);
    chk("idle_a2", 32'(FlAddr2), 32'd77);
    run(40);

    // Flush with only pregs 5, 6, 100 free.
    CommitMap = '1; CommitMap[5] = 1'b0; CommitMap[6] = 1'b0; CommitMap[100] = 1'b0;
    FlushReq = 1'b1; rand_rob(); tick(); FlushReq = 1'b0;
    chk("fl_clean", 32'(FlClean), 32'd1);
    while (m_cyc < 2) run(1);
    chk("fl_c2", 32'({FlAddr2, FlAddr1}), {18'd0, 7'd6, 7'd5});
    while (m_cyc < 26) run(1);
    chk("fl_c26", 32'(FlAddr1), 32'd100);
    chk("fl_c26_able", 32'({FlAble4, FlAble3, FlAble2, FlAble1}), 32'h1);
    run(12);

    // Flush in cycle 10 of a reset scan.
    Rest = 1'b1; tick(); Rest = 1'b0;
    while (m_cyc < 10) run(1);
    CommitMap = rand_map(); FlushReq = 1'b1; rand_rob(); tick(); FlushReq = 1'b0;
    chk("mid_clean", 32'(FlClean), 32'd1);
    run(32);
    chk("mid_hold32", 32'(RenameHold), 32'd1);
    run(1);
    chk("mid_hold33", 32'(RenameHold), 32'd0);
    run(10);

    // Multi-cycle flush, then reset colliding with flush.
    FlushReq = 1'b1;
    repeat (3) begin CommitMap = rand_map(); rand_rob(); tick(); end
    FlushReq = 1'b0;
    run(36);
    Rest = 1'b1; FlushReq = 1'b1; CommitMap = '0; tick();
    Rest = 1'b0; FlushReq = 1'b0;
    run(36);

    // Random rebuilds, including an all-free map to reach count saturation.
    for (int it = 0; it < 4; it++) begin
      CommitMap = (it == 1) ? '0 : rand_map();
      FlushReq = 1'b1; rand_rob(); tick(); FlushReq = 1'b0;
      run(34 + int'($urandom_range(0, 40)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
